// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display path
// (scan controller, digit data mux, segment decoder).
package seven_seg_pkg;

  localparam int NUM_DIGITS_DEF = 6;
  localparam int SEL_W          = 3;

  // Code the digit data mux outputs for select values beyond the last digit.
  localparam logic [3:0] BLANK_CODE = 4'hA;

  // Anodes are active-low, so all ones means every digit is dark.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef logic [SEL_W-1:0] digit_sel_t;

  function automatic logic [7:0] sel_onehot(input digit_sel_t sel);
    return 8'b1 << sel;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Scan controller bus: the host drives enable and the blank mask; the
// controller returns the digit select, the anode enables and the tick pulses.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = seven_seg_pkg::NUM_DIGITS_DEF
);

  logic                            en;
  logic [NUM_DIGITS-1:0]           blank_mask;
  logic [seven_seg_pkg::SEL_W-1:0] mux_sel;
  logic [NUM_DIGITS-1:0]           an_n;
  logic                            slot_tick;
  logic                            frame_tick;

  modport master (
    output en,
    output blank_mask,
    input  mux_sel,
    input  an_n,
    input  slot_tick,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  blank_mask,
    output mux_sel,
    output an_n,
    output slot_tick,
    output frame_tick
  );

endinterface

// File: rtl/seven_seg_prescaler.sv
// Modulo-PRESCALE counter with synchronous clear and a wrap pulse that is
// high during the last count of each period.
module seven_seg_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  // A pending clear wins over the wrap, so a cleared period never advances.
  assign wrap = !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: steps the digit select, drives the
// active-low anodes with a guard interval and blank mask, and emits ticks.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam digit_sel_t            LAST_SEL = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = NUM_DIGITS'(ANODE_OFF);

  logic                  clear;
  logic                  wrap;
  logic [CNT_W-1:0]      cnt;
  digit_sel_t            sel_q;
  digit_sel_t            sel_next;
  logic [NUM_DIGITS-1:0] digit_onehot;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  slot_q;
  logic                  frame_q;
  logic                  in_guard;
  logic                  masked;

  assign clear = ~bus.en;

  seven_seg_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .count (cnt),
    .wrap  (wrap)
  );

  assign sel_next     = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
  assign digit_onehot = NUM_DIGITS'(sel_onehot(sel_q));
  assign masked       = |(bus.blank_mask & digit_onehot);

  // With no guard configured the comparison would be constant, so drop it.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // Anodes follow the previous cycle's select, giving the data mux a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      an_q    <= ALL_OFF;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      an_q <= (!bus.en || in_guard || masked) ? ALL_OFF : ~digit_onehot;
      if (wrap) begin
        sel_q   <= sel_next;
        slot_q  <= 1'b1;
        frame_q <= (sel_next == '0);
      end else begin
        slot_q  <= 1'b0;
        frame_q <= 1'b0;
      end
    end
  end

  assign bus.mux_sel    = sel_q;
  assign bus.an_n       = an_q;
  assign bus.slot_tick  = slot_q;
  assign bus.frame_tick = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: a PRESCALE=8/BLANK=2 instance checked against
// hand vectors and a cycle model, plus a PRESCALE=2/BLANK=0 edge instance.
module tb_seven_seg_scan_ctrl;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(6)) bus_a ();
  seven_seg_scan_ctrl_if #(.NUM_DIGITS(6)) bus_b ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (6),
    .PRESCALE     (8),
    .BLANK_CYCLES (2),
    .CNT_W        (4)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (6),
    .PRESCALE     (2),
    .BLANK_CYCLES (0),
    .CNT_W        (2)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    int         sel;
    logic [5:0] an;
    logic       st;
    logic       ft;
  } mstate_t;

  typedef struct {
    logic       en;
    logic [5:0] mask;
    logic [2:0] sel;
    logic [5:0] an;
    logic       st;
    logic       ft;
  } vec_t;

  mstate_t ma;
  mstate_t mb;
  vec_t    vecs [13];

  function automatic mstate_t model_reset();
    mstate_t s;
    s.cnt = 0;
    s.sel = 0;
    s.an  = 6'h3F;
    s.st  = 1'b0;
    s.ft  = 1'b0;
    return s;
  endfunction

  // One clock of the scan behaviour, computed from the state before the edge.
  function automatic mstate_t model_step(input mstate_t s, input logic en,
                                         input logic [5:0] mask, input int p, input int b);
    mstate_t    n;
    logic [5:0] oh;
    n  = s;
    oh = 6'b1 << s.sel;
    n.an = (!en || s.cnt < b || mask[s.sel]) ? 6'h3F : ~oh;
    if (!en) begin
      n.cnt = 0;
      n.st  = 1'b0;
      n.ft  = 1'b0;
    end else if (s.cnt == p - 1) begin
      n.cnt = 0;
      n.sel = (s.sel == 5) ? 0 : s.sel + 1;
      n.st  = 1'b1;
      n.ft  = (n.sel == 0);
    end else begin
      n.cnt = s.cnt + 1;
      n.st  = 1'b0;
      n.ft  = 1'b0;
    end
    return n;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_a();
    check_output("a_mux_sel", 32'(bus_a.mux_sel), 32'(ma.sel));
    check_output("a_an_n", 32'(bus_a.an_n), 32'(ma.an));
    check_output("a_slot_tick", 32'(bus_a.slot_tick), 32'(ma.st));
    check_output("a_frame_tick", 32'(bus_a.frame_tick), 32'(ma.ft));
    check_output("a_an_onehot", 32'($countones(~bus_a.an_n) <= 1), 32'd1);
  endtask

  task automatic apply_stimulus_a(input logic en, input logic [5:0] mask);
    bus_a.en         = en;
    bus_a.blank_mask = mask;
    ma = model_step(ma, en, mask, 8, 2);
    @(posedge clk);
    #1;
    compare_a();
  endtask

  task automatic apply_stimulus_b(input logic en, input logic [5:0] mask);
    bus_b.en         = en;
    bus_b.blank_mask = mask;
    mb = model_step(mb, en, mask, 2, 0);
    @(posedge clk);
    #1;
    check_output("b_mux_sel", 32'(bus_b.mux_sel), 32'(mb.sel));
    check_output("b_an_n", 32'(bus_b.an_n), 32'(mb.an));
    check_output("b_slot_tick", 32'(bus_b.slot_tick), 32'(mb.st));
    check_output("b_frame_tick", 32'(bus_b.frame_tick), 32'(mb.ft));
    check_output("b_an_onehot", 32'($countones(~bus_b.an_n) <= 1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int         slot_cnt;
    int         frame_cnt;
    int         last_tick;
    bit         found;
    logic [5:0] exp_an_r [8];

    // Hand vectors from reset release: guard, slot 0, wrap, slot 1, mask toggle.
    vecs[0]  = '{1'b1, 6'h00, 3'd0, 6'h3F, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'h00, 3'd0, 6'h3F, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 6'h00, 3'd0, 6'h3E, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 6'h00, 3'd0, 6'h3E, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 6'h00, 3'd0, 6'h3E, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 6'h00, 3'd0, 6'h3E, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6'h00, 3'd0, 6'h3E, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 6'h00, 3'd1, 6'h3E, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 6'h00, 3'd1, 6'h3F, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 6'h00, 3'd1, 6'h3F, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 6'h00, 3'd1, 6'h3D, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 6'h02, 3'd1, 6'h3F, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 6'h00, 3'd1, 6'h3D, 1'b0, 1'b0};

    rst_n            = 1'b0;
    bus_a.en         = 1'b1;
    bus_a.blank_mask = 6'h00;
    bus_b.en         = 1'b0;
    bus_b.blank_mask = 6'h00;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_output("rst_an_n", 32'(bus_a.an_n), 32'h3F);
      check_output("rst_mux_sel", 32'(bus_a.mux_sel), 32'd0);
      check_output("rst_slot_tick", 32'(bus_a.slot_tick), 32'd0);
      check_output("rst_frame_tick", 32'(bus_a.frame_tick), 32'd0);
    end

    rst_n = 1'b1;
    ma    = model_reset();
    mb    = model_reset();

    for (int i = 0; i < 13; i++) begin
      apply_stimulus_a(vecs[i].en, vecs[i].mask);
      check_output("vec_mux_sel", 32'(bus_a.mux_sel), 32'(vecs[i].sel));
      check_output("vec_an_n", 32'(bus_a.an_n), 32'(vecs[i].an));
      check_output("vec_slot_tick", 32'(bus_a.slot_tick), 32'(vecs[i].st));
      check_output("vec_frame_tick", 32'(bus_a.frame_tick), 32'(vecs[i].ft));
    end

    // Free scan: starting at slot 1, cnt 5, 96 cycles hold 12 slots and 2 frame starts.
    slot_cnt  = 0;
    frame_cnt = 0;
    last_tick = -1;
    for (int i = 0; i < 96; i++) begin
      apply_stimulus_a(1'b1, 6'h00);
      if (bus_a.slot_tick) begin
        slot_cnt++;
        if (last_tick >= 0) check_output("slot_gap", 32'(i - last_tick), 32'd8);
        last_tick = i;
      end
      if (bus_a.frame_tick) begin
        frame_cnt++;
        check_output("frame_at_wrap", 32'(bus_a.slot_tick && bus_a.mux_sel == 3'd0), 32'd1);
      end
    end
    check_output("slot_tick_count", 32'(slot_cnt), 32'd12);
    check_output("frame_tick_count", 32'(frame_cnt), 32'd2);

    // Masked digits 4 and 5 stay dark while sequencing is unchanged.
    slot_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      apply_stimulus_a(1'b1, 6'b110000);
      check_output("mask_an_45_off", 32'(bus_a.an_n[5:4]), 32'd3);
      if (bus_a.slot_tick) slot_cnt++;
    end
    check_output("mask_slot_count", 32'(slot_cnt), 32'd6);

    // Drop enable at slot 3, cnt 5; hold 10 cycles; restart the held slot.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (ma.sel == 3 && ma.cnt == 5) found = 1'b1;
      else apply_stimulus_a(1'b1, 6'h00);
    end
    check_output("reach_slot3_cnt5", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus_a(1'b0, 6'h00);
      check_output("en_off_an_n", 32'(bus_a.an_n), 32'h3F);
      check_output("en_off_mux_sel", 32'(bus_a.mux_sel), 32'd3);
      check_output("en_off_tick", 32'(bus_a.slot_tick | bus_a.frame_tick), 32'd0);
    end
    exp_an_r = '{6'h3F, 6'h3F, 6'h37, 6'h37, 6'h37, 6'h37, 6'h37, 6'h37};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus_a(1'b1, 6'h00);
      check_output("en_on_an_n", 32'(bus_a.an_n), 32'(exp_an_r[i]));
      check_output("en_on_mux_sel", 32'(bus_a.mux_sel), (i == 7) ? 32'd4 : 32'd3);
      check_output("en_on_slot_tick", 32'(bus_a.slot_tick), (i == 7) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset mid-slot 3 while the anode is lit.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (ma.sel == 3 && ma.cnt == 4) found = 1'b1;
      else apply_stimulus_a(1'b1, 6'h00);
    end
    check_output("reach_slot3_cnt4", 32'(found), 32'd1);
    check_output("pre_reset_an_on", 32'(bus_a.an_n), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_an_n", 32'(bus_a.an_n), 32'h3F);
    check_output("async_rst_mux_sel", 32'(bus_a.mux_sel), 32'd0);
    check_output("async_rst_ticks", 32'(bus_a.slot_tick | bus_a.frame_tick), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ma    = model_reset();
    for (int i = 0; i < 20; i++) apply_stimulus_a(1'b1, 6'h00);

    // Edge instance: no guard, two-cycle slots, random masks.
    bus_a.en = 1'b0;
    mb       = model_reset();
    for (int i = 0; i < 100; i++) apply_stimulus_b(1'b1, 6'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 6-digit seven-segment display.
- Generates the digit select that drives the downstream 6:1 digit data mux.
- Generates the matching active-low digit anode enables.
- Adds a per-slot anode-off guard interval to prevent ghosting, a per-digit blank mask, and slot/frame tick pulses for the rest of the display path.

Parameters:
- NUM_DIGITS, 6: number of scanned digits; legal range 2..8; mux_sel only ever takes values 0..NUM_DIGITS-1.
- PRESCALE, 50000: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: anode-off guard cycles at the start of each slot; must be < PRESCALE; 0 disables the guard.
- CNT_W, 16: prescale counter width; must satisfy 2**CNT_W >= PRESCALE.

Ports:
- clk, input, 1: system clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable.
- blank_mask, input, NUM_DIGITS: 1 = keep that digit's anode off.
- mux_sel, output, 3: current digit index, fed to the digit data mux select.
- an_n, output, NUM_DIGITS: registered active-low anode enables, one-hot-low or all ones.
- slot_tick, output, 1: one-cycle pulse on the first cycle of each new slot.
- frame_tick, output, 1: one-cycle pulse on the first cycle of slot 0.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: cnt=0, mux_sel=0, an_n=all ones, slot_tick=0, frame_tick=0.
  - Outputs take these values immediately, without waiting for a clk edge.
  - Reset mid-slot abandons the slot; after release, scanning restarts at slot 0 with a full guard interval.
- Prescaler (en=1):
  - cnt counts 0..PRESCALE-1.
  - At cnt==PRESCALE-1: cnt goes to 0 and mux_sel advances by 1; at NUM_DIGITS-1 it wraps to 0.
- Ticks:
  - Registered, high in the cycle where cnt==0 after an advance.
  - frame_tick = slot_tick AND (new mux_sel==0).
  - No ticks are produced on en rising or on reset release.
- Anodes:
  - an_n is registered; at cycle t+1 it is f(cnt, mux_sel, blank_mask, en) sampled at cycle t.
  - all ones if en=0 OR cnt<BLANK_CYCLES OR blank_mask[mux_sel]=1.
  - Otherwise bit mux_sel=0 and all other bits=1.
  - This gives a 1-cycle lag behind mux_sel; the data path has settled by the time the anode turns on.
- en=0:
  - cnt cleared to 0; mux_sel holds; ticks are 0; an_n is all ones from the next edge.
  - On en returning to 1, the held slot restarts from cnt=0, so a full guard interval precedes the anode.
- blank_mask:
  - Sampled every cycle; a change mid-slot takes effect on the next edge.
  - Masking a digit never alters mux_sel sequencing or ticks.
- Invariants:
  - an_n never has more than one bit low.
  - mux_sel never reaches the mux's out-of-range (blank) codes.
  - Exactly one slot_tick per PRESCALE cycles while en=1.

Decomposition:
- Package seven_seg_pkg:
  - NUM_DIGITS default; SEL_W=3; BLANK_CODE=4'hA (the mux out-of-range output).
  - Anode-off constant (all ones).
  - Shared with the digit mux and segment decoder.
- Sub-module seven_seg_prescaler:
  - Generic modulo-PRESCALE counter with clear input, count output and wrap pulse.
  - The scan controller instantiates it and holds the digit index, tick and anode registers.

Test Plan (PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=6 unless stated):
- Reset with rst_n=0, en=1 held 20 cycles -> an_n=6'b111111, mux_sel=0, slot_tick=frame_tick=0 throughout. Assert rst_n asynchronously mid-slot 3 -> an_n=111111 and mux_sel=0 before the next clk edge.
- Free scan, en=1, blank_mask=0 -> mux_sel steps 0,1,2,3,4,5,0 every 8 cycles. slot_tick every 8 cycles; frame_tick every 48 and coincident with slot_tick at the 5->0 wrap. Per slot: 2 cycles an_n=111111, then 6 cycles 6'b111110 (slot 0) / 6'b111101 (slot 1), each lagging cnt by 1 cycle.
- blank_mask=6'b110000 -> slots 4 and 5 keep an_n=111111 for all 8 cycles; mux_sel and ticks are unchanged versus the unmasked run.
- en dropped at slot 3, cnt=5 -> next edge an_n=111111, mux_sel holds 3, no ticks for 10 cycles. en raised -> 2 guard cycles, then an_n=6'b110111 for 6 cycles, then slot_tick with mux_sel=4.
- Edge parameters BLANK_CYCLES=0, PRESCALE=2 -> anode is on from the cycle after each advance; mux_sel changes every 2 cycles. Check an_n is never multi-hot across 100 cycles with random blank_mask.
